rf_commit_ctrl: RTL and testbench

- Sequences the register file's commit and clear ports for the out-of-order RISC-V core.
- Accepts retired results from the ROB head through a valid/ready handshake and buffers them in a small in-order FIFO.
- Drives at most one register file commit per cycle.
- On a misprediction, drains all buffered commits, then pulses the register file's tag clear, stalls issue for the whole flush sequence, and reports completion.

---
 rtl/rf_commit_pkg.sv | 16 +
 rtl/rf_commit_ctrl_fifo.sv | 48 ++++
 rtl/rf_commit_ctrl.sv | 150 +++++++++++++++
 tb/tb_rf_commit_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rf_commit_pkg.sv
// Shared definitions for the register file commit controller.
// Holds FSM state encodings, default tag width and commit entry field widths.
package rf_commit_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_ROB_WIDTH = 4;
    localparam int RD_ID_W       = 5;
    localparam int VALUE_W       = 32;

endpackage

// File: rtl/rf_commit_ctrl_fifo.sv
// commit_fifo: small in-order synchronous FIFO for retired commit entries.
// Ports: clk, rst_n (async low), push/din, pop, full, empty, count, head.
module commit_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_q;

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rptr];

endmodule

// File: rtl/rf_commit_ctrl.sv
// Register file commit/clear sequencer: buffers ROB retirements, commits one
// per cycle, and runs the drain/clear/done flush sequence on a misprediction.
// Ports: clk_in, rst_n_in, rdy_in, ROB handshake (rob_*), flush_req_in,
// flush_done_out, issue_stall_out, rf_commit_* and rf_clear_signal_out.
// Optional RF_COMMIT_PERF_EN adds retire_count_out and flush_count_out.
module rf_commit_ctrl
    import rf_commit_pkg::*;
#(
    parameter int ROB_WIDTH = DEF_ROB_WIDTH,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 rob_valid_in,
    output logic                 rob_ready_out,
    input  logic [RD_ID_W-1:0]   rob_rd_id_in,
    input  logic [ROB_WIDTH-1:0] rob_rd_tag_in,
    input  logic [VALUE_W-1:0]   rob_rd_value_in,
    input  logic                 flush_req_in,
    output logic                 flush_done_out,
    output logic                 issue_stall_out,
    output logic                 rf_commit_signal_out,
    output logic [RD_ID_W-1:0]   rf_commit_rd_id_out,
    output logic [ROB_WIDTH-1:0] rf_commit_rd_tag_out,
    output logic [VALUE_W-1:0]   rf_commit_rd_value_out,
    output logic                 rf_clear_signal_out
`ifdef RF_COMMIT_PERF_EN
    ,
    output logic [63:0]          retire_count_out,
    output logic [31:0]          flush_count_out
`endif
);

    localparam int EW = RD_ID_W + ROB_WIDTH + VALUE_W;
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    state_e state_q;
    state_e state_d;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          last;
    logic          busy_after;
    logic [CW-1:0] count;
    logic [EW-1:0] head;

    logic [RD_ID_W-1:0]   head_rd;
    logic [ROB_WIDTH-1:0] head_tag;
    logic [VALUE_W-1:0]   head_val;

    logic                 commit_q;
    logic [RD_ID_W-1:0]   rd_q;
    logic [ROB_WIDTH-1:0] tag_q;
    logic [VALUE_W-1:0]   val_q;
    logic                 clear_q;
    logic                 done_q;
    logic                 stall_q;

    assign rob_ready_out = rst_n_in & rdy_in & (state_q == RUN) & ~full;
    assign push = rob_valid_in & rob_ready_out;
    assign pop  = rdy_in & ~empty;
    assign last = (count == CW'(1));
    assign {head_rd, head_tag, head_val} = head;

    // FIFO still holds something after this edge's push/pop.
    assign busy_after = push | (~empty & ~(pop & last));

    commit_fifo #(
        .WIDTH (EW),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (push),
        .din   ({rob_rd_id_in, rob_rd_tag_in, rob_rd_value_in}),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (flush_req_in) state_d = busy_after ? DRAIN : CLEAR;
            DRAIN: if (pop && last) state_d = CLEAR;
            CLEAR: state_d = DONE;
            DONE:  state_d = RUN;
            default: state_d = RUN;
        endcase
        if (!rdy_in) state_d = state_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= RUN;
            commit_q <= 1'b0;
            rd_q     <= '0;
            tag_q    <= '0;
            val_q    <= '0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
            stall_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q  <= state_d;
            // x0 writes are retired but never reach the register file.
            commit_q <= pop && (head_rd != '0);
            if (pop) begin
                rd_q  <= head_rd;
                tag_q <= head_tag;
                val_q <= head_val;
            end
            clear_q <= (state_d == CLEAR);
            done_q  <= (state_d == DONE);
            stall_q <= (state_d != RUN);
        end
    end

    assign rf_commit_signal_out   = commit_q;
    assign rf_commit_rd_id_out    = rd_q;
    assign rf_commit_rd_tag_out   = tag_q;
    assign rf_commit_rd_value_out = val_q;
    assign rf_clear_signal_out    = clear_q;
    assign flush_done_out         = done_q;
    assign issue_stall_out        = stall_q;

`ifdef RF_COMMIT_PERF_EN
    logic [63:0] retire_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            retire_q <= '0;
            flush_q  <= '0;
        end else if (rdy_in) begin
            if (pop) retire_q <= retire_q + 64'd1;
            if (state_q != CLEAR && state_d == CLEAR)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign retire_count_out = retire_q;
    assign flush_count_out  = flush_q;
`endif

endmodule

// File: tb/tb_rf_commit_ctrl.sv
// Self-checking bench for rf_commit_ctrl: per-cycle vector table plus
// hand-written reset-during-flush sequence.
module tb_rf_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        valid;
    logic        ready;
    logic [4:0]  rd;
    logic [3:0]  tag;
    logic [31:0] val;
    logic        flush;
    logic        done;
    logic        stall;
    logic        commit;
    logic [4:0]  c_rd;
    logic [3:0]  c_tag;
    logic [31:0] c_val;
    logic        clear;
`ifdef RF_COMMIT_PERF_EN
    logic [63:0] retire_cnt;
    logic [31:0] flush_cnt;
`endif

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rf_commit_ctrl #(.ROB_WIDTH(4), .BUF_DEPTH(2)) dut (
        .clk_in                 (clk),
        .rst_n_in               (rst_n),
        .rdy_in                 (rdy),
        .rob_valid_in           (valid),
        .rob_ready_out          (ready),
        .rob_rd_id_in           (rd),
        .rob_rd_tag_in          (tag),
        .rob_rd_value_in        (val),
        .flush_req_in           (flush),
        .flush_done_out         (done),
        .issue_stall_out        (stall),
        .rf_commit_signal_out   (commit),
        .rf_commit_rd_id_out    (c_rd),
        .rf_commit_rd_tag_out   (c_tag),
        .rf_commit_rd_value_out (c_val),
        .rf_clear_signal_out    (clear)
`ifdef RF_COMMIT_PERF_EN
        ,
        .retire_count_out       (retire_cnt),
        .flush_count_out        (flush_cnt)
`endif
    );

    typedef struct {
        logic        rdy;
        logic        v;
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] val;
        logic        fl;
        logic        e_rdy;
        logic        e_cm;
        logic [4:0]  e_rd;
        logic [3:0]  e_tag;
        logic [31:0] e_val;
        logic        e_clr;
        logic        e_done;
        logic        e_stall;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mk(
        logic r, logic v, logic [4:0] d, logic [3:0] t, logic [31:0] x,
        logic f, logic er, logic ec, logic [4:0] ed, logic [3:0] et,
        logic [31:0] ex, logic el, logic eo, logic es);
        vec_t s;
        s.rdy = r;  s.v = v;  s.rd = d;  s.tag = t;  s.val = x;  s.fl = f;
        s.e_rdy = er;  s.e_cm = ec;  s.e_rd = ed;  s.e_tag = et;
        s.e_val = ex;  s.e_clr = el;  s.e_done = eo;  s.e_stall = es;
        return s;
    endfunction

    task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_out(int i, logic er, logic ec, logic [4:0] ed,
                           logic [3:0] et, logic [31:0] ex, logic el,
                           logic eo, logic es);
        chk("ready",  i, 64'(ready),  64'(er));
        chk("commit", i, 64'(commit), 64'(ec));
        chk("rd",     i, 64'(c_rd),   64'(ed));
        chk("tag",    i, 64'(c_tag),  64'(et));
        chk("value",  i, 64'(c_val),  64'(ex));
        chk("clear",  i, 64'(clear),  64'(el));
        chk("done",   i, 64'(done),   64'(eo));
        chk("stall",  i, 64'(stall),  64'(es));
    endtask

    initial begin
        //            rdy v  rd  tg val           fl  rdy cm rd  tg val           cl dn st
        tbl[0]  = mk(1, 0, 0,  0, 32'h0,        0,  1, 0, 0,  0, 32'h0,        0, 0, 0);
        tbl[1]  = mk(1, 1, 5,  3, 32'hDEADBEEF, 0,  1, 0, 0,  0, 32'h0,        0, 0, 0);
        tbl[2]  = mk(1, 1, 6,  4, 32'h1,        0,  1, 0, 0,  0, 32'h0,        0, 0, 0);
        tbl[3]  = mk(1, 0, 0,  0, 32'h0,        0,  1, 1, 5,  3, 32'hDEADBEEF, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0,  0, 32'h0,        0,  1, 1, 6,  4, 32'h1,        0, 0, 0);
        tbl[5]  = mk(1, 1, 0,  2, 32'h55,       0,  1, 0, 6,  4, 32'h1,        0, 0, 0);
        tbl[6]  = mk(1, 0, 0,  0, 32'h0,        0,  1, 0, 6,  4, 32'h1,        0, 0, 0);
        tbl[7]  = mk(1, 0, 0,  0, 32'h0,        0,  1, 0, 0,  2, 32'h55,       0, 0, 0);
        tbl[8]  = mk(0, 1, 7,  5, 32'h7,        0,  0, 0, 0,  2, 32'h55,       0, 0, 0);
        tbl[9]  = mk(1, 1, 7,  5, 32'h7,        0,  1, 0, 0,  2, 32'h55,       0, 0, 0);
        tbl[10] = mk(0, 1, 8,  6, 32'h8,        0,  0, 0, 0,  2, 32'h55,       0, 0, 0);
        tbl[11] = mk(1, 1, 8,  6, 32'h8,        0,  1, 0, 0,  2, 32'h55,       0, 0, 0);
        tbl[12] = mk(0, 0, 0,  0, 32'h0,        0,  0, 1, 7,  5, 32'h7,        0, 0, 0);
        tbl[13] = mk(0, 0, 0,  0, 32'h0,        0,  0, 1, 7,  5, 32'h7,        0, 0, 0);
        tbl[14] = mk(1, 0, 0,  0, 32'h0,        0,  1, 1, 7,  5, 32'h7,        0, 0, 0);
        tbl[15] = mk(1, 0, 0,  0, 32'h0,        0,  1, 1, 8,  6, 32'h8,        0, 0, 0);
        tbl[16] = mk(1, 0, 0,  0, 32'h0,        0,  1, 0, 8,  6, 32'h8,        0, 0, 0);
        tbl[17] = mk(1, 0, 0,  0, 32'h0,        1,  1, 0, 8,  6, 32'h8,        0, 0, 0);
        tbl[18] = mk(1, 0, 0,  0, 32'h0,        0,  0, 0, 8,  6, 32'h8,        1, 0, 1);
        tbl[19] = mk(1, 1, 9,  7, 32'h9,        0,  0, 0, 8,  6, 32'h8,        0, 1, 1);
        tbl[20] = mk(1, 1, 9,  7, 32'h9,        0,  1, 0, 8,  6, 32'h8,        0, 0, 0);
        tbl[21] = mk(1, 1, 10, 8, 32'hA,        1,  1, 0, 8,  6, 32'h8,        0, 0, 0);
        tbl[22] = mk(1, 1, 11, 9, 32'hB,        0,  0, 1, 9,  7, 32'h9,        0, 0, 1);
        tbl[23] = mk(1, 0, 0,  0, 32'h0,        1,  0, 1, 10, 8, 32'hA,        1, 0, 1);
        tbl[24] = mk(1, 0, 0,  0, 32'h0,        0,  0, 0, 10, 8, 32'hA,        0, 1, 1);
        tbl[25] = mk(1, 0, 0,  0, 32'h0,        0,  1, 0, 10, 8, 32'hA,        0, 0, 0);
        tbl[26] = mk(1, 0, 0,  0, 32'h0,        0,  1, 0, 10, 8, 32'hA,        0, 0, 0);

        rst_n = 1'b0;
        rdy   = 1'b0;
        valid = 1'b0;
        rd    = '0;
        tag   = '0;
        val   = '0;
        flush = 1'b0;

        repeat (2) @(negedge clk);
        rdy = 1'b1;
        #1;
        chk_out(-1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        rdy   = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rdy   = tbl[i].rdy;
            valid = tbl[i].v;
            rd    = tbl[i].rd;
            tag   = tbl[i].tag;
            val   = tbl[i].val;
            flush = tbl[i].fl;
            #1;
            chk_out(i, tbl[i].e_rdy, tbl[i].e_cm, tbl[i].e_rd, tbl[i].e_tag,
                    tbl[i].e_val, tbl[i].e_clr, tbl[i].e_done, tbl[i].e_stall);
        end

`ifdef RF_COMMIT_PERF_EN
        chk("retire_count", NV, retire_cnt, 64'd7);
        chk("flush_count",  NV, 64'(flush_cnt), 64'd2);
`endif

        // Reset asserted while draining one buffered entry.
        @(negedge clk);
        rdy = 1'b1; valid = 1'b1; rd = 12; tag = 1; val = 32'hC; flush = 1'b0;
        @(negedge clk);
        rd = 13; tag = 2; val = 32'hD; flush = 1'b1;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        #1;
        chk_out(100, 0, 1, 12, 1, 32'hC, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out(101, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out(102, 1, 0, 0, 0, 32'h0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk_out(103 + k, 1, 0, 0, 0, 32'h0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
